bitmap_ram_writer: RTL and testbench

Fills a 1-bit-wide bitmap RAM (the image store that the LCD path reads pixel-by-pixel) from a byte stream supplied by the CPU/bus side. Each accepted byte is unpacked MSB-first into eight consecutive single-bit RAM writes at incrementing addresses. One frame fill starts at address 0 and ends after exactly FRAME_BITS writes. This block is the write-side counterpart of the synchronous bitmap read port.

---
 rtl/bitmap_ram_writer.sv | 140 ++++++++++++++
 tb/tb_bitmap_ram_writer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitmap_ram_writer.sv
// rtl/bitmap_ram_writer.sv - unpacks a byte stream MSB-first into 1-bit bitmap RAM writes
//
// Fills one frame of a 1-bit-wide bitmap RAM starting at address 0. Each
// accepted byte becomes up to eight single-bit writes at incrementing
// addresses, bit 7 first. The frame ends after exactly FRAME_BITS writes.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start_i  begin a frame fill (honoured only in IDLE)
//   abort_i  return to IDLE on the next edge, no done pulse
//   data_i   packed pixel byte, bit 7 = first pixel
//   valid_i  data_i valid
//   ready_o  byte accepted this cycle when valid_i is high (combinational)
//   we_o     RAM write enable (registered)
//   waddr_o  RAM write address (registered)
//   wdata_o  RAM write data (registered)
//   busy_o   frame fill in progress (registered)
//   done_o   one-cycle pulse after the final write (registered)
module bitmap_ram_writer #(
  parameter int ADDR_WIDTH = 17,
  parameter int FRAME_BITS = 76800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic                  wdata_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, DONE} state_t;

  // One extra bit so the "next pixel" index can represent FRAME_BITS itself.
  localparam logic [ADDR_WIDTH:0] FRAME_END = (ADDR_WIDTH+1)'(FRAME_BITS);
  localparam logic [ADDR_WIDTH:0] EIGHT     = (ADDR_WIDTH+1)'(8);

  state_t                state;
  logic [ADDR_WIDTH:0]   idx;    // next pixel to be written
  logic [7:0]            shreg;  // remaining bits of the current byte, next at [7]
  logic [2:0]            cnt;    // writes still to come for the current byte

  logic                  pixels_left;
  logic                  last_bit;
  logic                  accept;
  logic [ADDR_WIDTH:0]   rem;
  logic [2:0]            first_cnt;

  assign pixels_left = (idx != FRAME_END);
  assign last_bit    = (state == SHIFT) && (cnt == 3'd0);
  // Ready during a byte's final write cycle keeps the stream bubble-free.
  assign ready_o     = (state == WAIT_BYTE) || (last_bit && pixels_left);
  assign accept      = valid_i && ready_o;

  // The final byte may carry fewer than eight real pixels; its low bits are dropped.
  assign rem       = FRAME_END - idx;
  assign first_cnt = (rem >= EIGHT) ? 3'd7 : (rem[2:0] - 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      shreg   <= '0;
      cnt     <= '0;
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else if (abort_i) begin
      // Abort wins over start and byte acceptance; the in-flight byte is dropped.
      state  <= IDLE;
      we_o   <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          we_o   <= 1'b0;
          done_o <= 1'b0;
          if (start_i) begin
            state  <= WAIT_BYTE;
            idx    <= '0;
            busy_o <= 1'b1;
          end
        end
        WAIT_BYTE: begin
          if (accept) begin
            state   <= SHIFT;
            we_o    <= 1'b1;
            wdata_o <= data_i[7];
            waddr_o <= idx[ADDR_WIDTH-1:0];
            shreg   <= {data_i[6:0], 1'b0};
            idx     <= idx + 1'b1;
            cnt     <= first_cnt;
          end else begin
            we_o <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt != 3'd0) begin
            we_o    <= 1'b1;
            wdata_o <= shreg[7];
            waddr_o <= idx[ADDR_WIDTH-1:0];
            shreg   <= {shreg[6:0], 1'b0};
            idx     <= idx + 1'b1;
            cnt     <= cnt - 3'd1;
          end else if (!pixels_left) begin
            state  <= DONE;
            we_o   <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (accept) begin
            we_o    <= 1'b1;
            wdata_o <= data_i[7];
            waddr_o <= idx[ADDR_WIDTH-1:0];
            shreg   <= {data_i[6:0], 1'b0};
            idx     <= idx + 1'b1;
            cnt     <= first_cnt;
          end else begin
            state <= WAIT_BYTE;
            we_o  <= 1'b0;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitmap_ram_writer.sv
// tb/tb_bitmap_ram_writer.sv - directed bench for bitmap_ram_writer
module tb_bitmap_ram_writer;

  localparam int FB [4] = '{8, 12, 40, 76800};

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic [7:0]  data;
  logic        valid;
  logic        start [4];
  logic        ready [4];
  logic        we    [4];
  logic [16:0] waddr [4];
  logic        wdata [4];
  logic        busy  [4];
  logic        done  [4];

  logic [7:0]  byte_q [0:9599];
  logic        ram    [0:76799];

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    bitmap_ram_writer #(.ADDR_WIDTH(17), .FRAME_BITS(FB[g])) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start[g]),
      .abort_i (abort),
      .data_i  (data),
      .valid_i (valid),
      .ready_o (ready[g]),
      .we_o    (we[g]),
      .waddr_o (waddr[g]),
      .wdata_o (wdata[g]),
      .busy_o  (busy[g]),
      .done_o  (done[g])
    );
  end

  function automatic logic exp_bit(input int a);
    logic [7:0] b;
    b = byte_q[a / 8];
    return b[7 - (a % 8)];
  endfunction

  // Runs one fill on DUT k; optional random valid gaps; abort_at >= 0 aborts
  // in the cycle that shows the write to that address.
  task automatic fill(input int k, input int nbytes, input bit gaps, input int abort_at);
    int exp_addr, bidx, cyc;
    bit fin, acc, acc_prev, prev_we, valid_v;
    exp_addr = 0; bidx = 0; cyc = 0; fin = 0; acc_prev = 0; prev_we = 0;
    for (int i = 0; i < FB[k]; i++) ram[i] = 1'bx;
    @(negedge clk); start[k] = 1'b1;
    @(negedge clk); start[k] = 1'b0;
    n_vec++;
    if (busy[k] !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start dut%0d got %b exp 1", k, busy[k]);
    end
    while (!fin) begin
      acc = 1'b0;
      if (we[k] === 1'b1) begin
        n_vec++;
        if (waddr[k] !== 17'(exp_addr) || wdata[k] !== exp_bit(exp_addr)) begin
          n_fail++;
          $display("FAIL write dut%0d got addr %0d data %b exp addr %0d data %b",
                   k, waddr[k], wdata[k], exp_addr, exp_bit(exp_addr));
        end
        ram[exp_addr] = wdata[k];
        exp_addr++;
        if (abort_at == exp_addr - 1) begin
          abort = 1'b1; valid = 1'b0; fin = 1'b1;
        end
      end else if (done[k] === 1'b1) begin
        n_vec++;
        if (exp_addr != FB[k] || !prev_we || busy[k] !== 1'b0 || ready[k] !== 1'b0 || abort_at >= 0) begin
          n_fail++;
          $display("FAIL done dut%0d got writes %0d prev_we %b busy %b ready %b exp writes %0d prev_we 1 busy 0 ready 0",
                   k, exp_addr, prev_we, busy[k], ready[k], FB[k]);
        end
        fin = 1'b1;
      end else begin
        n_vec++;
        if ((!gaps && exp_addr > 0) || acc_prev || ready[k] !== 1'b1) begin
          n_fail++;
          $display("FAIL wait dut%0d got we 0 ready %b after_accept %b exp we 1 or waiting with ready 1",
                   k, ready[k], acc_prev);
        end
      end
      if (bidx == nbytes && !fin) begin
        n_vec++;
        if (ready[k] !== 1'b0) begin
          n_fail++; $display("FAIL ready_after_last dut%0d got %b exp 0", k, ready[k]);
        end
      end
      if (!fin) begin
        valid_v = (bidx < nbytes) && (!gaps || $urandom_range(0, 2) != 0);
        valid = valid_v;
        data  = (bidx < nbytes) ? byte_q[bidx] : 8'h00;
        acc   = valid_v && (ready[k] === 1'b1);
        if (acc) bidx++;
      end
      prev_we  = (we[k] === 1'b1);
      acc_prev = acc;
      cyc++;
      if (cyc > 4 * FB[k] + 200) begin
        n_fail++; $display("FAIL timeout dut%0d got writes %0d exp %0d", k, exp_addr, FB[k]);
        fin = 1'b1;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    abort = 1'b0;
    if (abort_at >= 0) begin
      for (int c = 0; c < 3; c++) begin
        n_vec++;
        if (we[k] !== 1'b0 || busy[k] !== 1'b0 || done[k] !== 1'b0 || ready[k] !== 1'b0 ||
            exp_addr != abort_at + 1) begin
          n_fail++;
          $display("FAIL after_abort dut%0d got we %b busy %b done %b ready %b writes %0d exp 0 0 0 0 %0d",
                   k, we[k], busy[k], done[k], ready[k], exp_addr, abort_at + 1);
        end
        @(negedge clk);
      end
    end else begin
      n_vec++;
      if (done[k] !== 1'b0 || ready[k] !== 1'b0 || we[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL after_done dut%0d got done %b ready %b we %b exp 0 0 0", k, done[k], ready[k], we[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; abort = 1'b0; valid = 1'b0; data = 8'h00;
    for (int k = 0; k < 4; k++) start[k] = 1'b0;
    #12;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (we[k] !== 1'b0 || waddr[k] !== 17'd0 || wdata[k] !== 1'b0 || busy[k] !== 1'b0 ||
          done[k] !== 1'b0 || ready[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d got we %b addr %0d data %b busy %b done %b ready %b exp all 0",
                 k, we[k], waddr[k], wdata[k], busy[k], done[k], ready[k]);
      end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single_byte();
    logic [7:0] got;
    byte_q[0] = 8'hA5;
    fill(0, 1, 1'b0, -1);
    for (int i = 0; i < 8; i++) got[7 - i] = ram[i];
    n_vec++;
    if (got !== 8'b1010_0101) begin
      n_fail++; $display("FAIL single_byte got %b exp 10100101", got);
    end
  endtask

  task automatic test_partial_byte();
    logic [11:0] got;
    byte_q[0] = 8'hFF; byte_q[1] = 8'h3C;
    fill(1, 2, 1'b0, -1);
    for (int i = 0; i < 12; i++) got[11 - i] = ram[i];
    n_vec++;
    if (got !== 12'b1111_1111_0011) begin
      n_fail++; $display("FAIL partial_byte got %b exp 111111110011", got);
    end
  endtask

  task automatic test_gaps();
    int bad;
    for (int i = 0; i < 5; i++) byte_q[i] = 8'($urandom);
    fill(2, 5, 1'b1, -1);
    bad = 0;
    for (int i = 0; i < 40; i++) if (ram[i] !== exp_bit(i)) bad++;
    n_vec++;
    if (bad != 0) begin
      n_fail++; $display("FAIL gaps_ram got %0d bad bits exp 0", bad);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 9600; i++) byte_q[i] = 8'($urandom);
    fill(3, 9600, 1'b0, 37);
    @(negedge clk); start[3] = 1'b1;
    @(negedge clk); start[3] = 1'b0; valid = 1'b1; data = 8'h80;
    @(negedge clk); valid = 1'b0;
    n_vec++;
    if (we[3] !== 1'b1 || waddr[3] !== 17'd0 || wdata[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL restart got we %b addr %0d data %b exp 1 0 1", we[3], waddr[3], wdata[3]);
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_vec++;
    if (we[3] !== 1'b0 || busy[3] !== 1'b0) begin
      n_fail++; $display("FAIL restart_abort got we %b busy %b exp 0 0", we[3], busy[3]);
    end
  endtask

  task automatic test_start_busy_and_reset();
    int n;
    n = 0;
    @(negedge clk); start[3] = 1'b1;
    @(negedge clk); start[3] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (we[3] === 1'b1) begin
        n_vec++;
        if (waddr[3] !== 17'(n)) begin
          n_fail++; $display("FAIL start_busy addr got %0d exp %0d", waddr[3], n);
        end
        n++;
      end
      valid = 1'b1; data = byte_q[c];
      start[3] = (c == 15);
      @(negedge clk);
    end
    start[3] = 1'b0;
    n_vec++;
    if (n != 29) begin
      n_fail++; $display("FAIL start_busy writes got %0d exp 29", n);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (we[3] !== 1'b0 || busy[3] !== 1'b0 || ready[3] !== 1'b0 || waddr[3] !== 17'd0) begin
      n_fail++;
      $display("FAIL async_reset got we %b busy %b ready %b addr %0d exp 0 0 0 0",
               we[3], busy[3], ready[3], waddr[3]);
    end
    valid = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_full_frame();
    logic [7:0] last_byte;
    fill(3, 9600, 1'b0, -1);
    last_byte = byte_q[9599];
    n_vec++;
    if (ram[76799] !== last_byte[0]) begin
      n_fail++; $display("FAIL full_last_bit got %b exp %b", ram[76799], last_byte[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_partial_byte();
    test_gaps();
    test_abort();
    test_start_busy_and_reset();
    test_full_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
